// File: rtl/rgb_pwm_pkg.sv
// Shared constants and types for the RGB PWM monitor.
package rgb_pwm_pkg;

  localparam int NUM_CH = 3;
  localparam int CH_R   = 0;
  localparam int CH_G   = 1;
  localparam int CH_B   = 2;

  typedef enum logic {
    IDLE,
    MEASURE
  } state_e;

endpackage

// File: rtl/pwm_capture_ch.sv
// One PWM capture channel: synchronizer, rising-edge detect, period/on-time
// counters, stuck detection and registered result outputs.
module pwm_capture_ch
  import rgb_pwm_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pwm,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             valid,
  output logic             stuck,
  output logic             level
);

  localparam logic             IDLE_PIN = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] TIMEOUT  = CNT_W'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_prev;
  logic                   rise;
  state_e                 state_q;
  state_e                 state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       hi_q;
  logic [CNT_W-1:0]       hi_d;
  logic                   take_meas;
  logic                   take_tmo;

  // Synchronizer resets to the idle pin level so release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE_PIN}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
    end
  end

  assign s    = sync_q[SYNC_STAGES-1] ^ IDLE_PIN;
  assign rise = s & ~s_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      s_prev  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      s_prev  <= s;
    end
  end

  // A rise takes priority over a timeout landing in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    take_meas = 1'b0;
    take_tmo  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          cnt_d   = CNT_W'(1);
          hi_d    = CNT_W'(1);
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (rise) begin
          take_meas = 1'b1;
          cnt_d     = CNT_W'(1);
          hi_d      = CNT_W'(1);
        end else if (cnt_q == TIMEOUT) begin
          take_tmo = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          hi_d  = hi_q + CNT_W'(s);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period <= '0;
      high   <= '0;
      valid  <= 1'b0;
      stuck  <= 1'b0;
      level  <= 1'b0;
    end else begin
      valid <= take_meas | take_tmo;
      if (take_meas) begin
        period <= cnt_q;
        high   <= hi_q;
        stuck  <= 1'b0;
      end else if (take_tmo) begin
        period <= '0;
        high   <= '0;
        stuck  <= 1'b1;
        level  <= s;
      end
    end
  end

endmodule

// File: rtl/rgb_pwm_monitor.sv
// Three-channel PWM period/duty monitor for the RGB LED pins; one independent
// capture channel per colour, results packed channel-major.
module rgb_pwm_monitor
  import rgb_pwm_pkg::*;
#(
  parameter int CNT_W          = 16,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter bit ACTIVE_LOW     = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       pwm_i,
  output logic [NUM_CH*CNT_W-1:0] period_o,
  output logic [NUM_CH*CNT_W-1:0] high_o,
  output logic [NUM_CH-1:0]       valid_o,
  output logic [NUM_CH-1:0]       stuck_o,
  output logic [NUM_CH-1:0]       level_o
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_capture_ch #(
      .CNT_W         (CNT_W),
      .SYNC_STAGES   (SYNC_STAGES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk   (clk),
      .rst_n (rst_n),
      .pwm   (pwm_i[i]),
      .period(period_o[i*CNT_W +: CNT_W]),
      .high  (high_o[i*CNT_W +: CNT_W]),
      .valid (valid_o[i]),
      .stuck (stuck_o[i]),
      .level (level_o[i])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_monitor.sv
// Directed bench for rgb_pwm_monitor: an active-high-pin instance and an
// active-low-pin instance, both with a 100-cycle timeout.
module tb_rgb_pwm_monitor;

  localparam int CNT_W = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  pwm;
  logic [2:0]  pwm_al;
  logic [47:0] period_o, high_o, period_al, high_al;
  logic [2:0]  valid_o, stuck_o, level_o;
  logic [2:0]  valid_al, stuck_al, level_al;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int valid_cyc;
  int prev_cyc;
  logic [2:0] vseen;

  // Pattern generators: index 0..2 drive dut, index 3 drives dut_al channel R.
  bit   gen_on[4];
  logic hold_lvl[4];
  int   gen_hi[4];
  int   gen_per[4];
  int   phase[4];

  rgb_pwm_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .pwm_i(pwm), .period_o(period_o), .high_o(high_o),
    .valid_o(valid_o), .stuck_o(stuck_o), .level_o(level_o)
  );

  rgb_pwm_monitor #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_CYCLES(100), .ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .pwm_i(pwm_al), .period_o(period_al), .high_o(high_al),
    .valid_o(valid_al), .stuck_o(stuck_al), .level_o(level_al)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] per(input int ch);
    return period_o[ch*CNT_W +: CNT_W];
  endfunction

  function automatic logic [15:0] hiw(input int ch);
    return high_o[ch*CNT_W +: CNT_W];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_gen(input int c, input int hi, input int per_len);
    gen_on[c]  = 1'b1;
    gen_hi[c]  = hi;
    gen_per[c] = per_len;
    phase[c]   = 0;
  endtask

  task automatic hold_gen(input int c, input logic lvl);
    gen_on[c]   = 1'b0;
    hold_lvl[c] = lvl;
  endtask

  // One clock: outputs are read 1ns after the edge, then pins advance.
  task automatic tick();
    logic [3:0] raw;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) begin
      if (gen_on[c]) begin
        raw[c]   = (phase[c] < gen_hi[c]);
        phase[c] = (phase[c] + 1) % gen_per[c];
      end else begin
        raw[c] = hold_lvl[c];
      end
    end
    pwm    = raw[2:0];
    pwm_al = {2'b11, ~raw[3]};
    cyc++;
    vseen  = vseen | valid_o;
  endtask

  task automatic wait_valid(input int which, input int ch, input int budget, input string tag);
    logic got;
    int   n;
    got = 1'b0;
    n   = 0;
    while (n < budget && !got) begin
      tick();
      n++;
      got = (which == 0) ? valid_o[ch] : valid_al[ch];
    end
    check({tag, "_seen"}, {31'd0, got}, 32'd1);
    valid_cyc = cyc;
  endtask

  task automatic do_reset();
    for (int c = 0; c < 4; c++) hold_gen(c, 1'b0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    vseen = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    pwm    = 3'b000;
    pwm_al = 3'b111;
    vseen  = '0;
    for (int c = 0; c < 4; c++) begin
      gen_on[c] = 1'b0; hold_lvl[c] = 1'b0; gen_hi[c] = 0; gen_per[c] = 1; phase[c] = 0;
    end
    do_reset();

    check("rst_period", period_o, 48'd0);
    check("rst_high", high_o, 48'd0);
    check("rst_valid", valid_o, 3'b000);
    check("rst_stuck", stuck_o, 3'b000);
    check("rst_level", level_o, 3'b000);
    check("rst_al_period", period_al, 48'd0);
    check("rst_al_stuck", stuck_al, 3'b000);

    // R: 3 on / 5 off
    set_gen(0, 3, 8);
    wait_valid(0, 0, 30, "r1");
    check("r1_mask", valid_o, 3'b001);
    check("r1_period", per(0), 16'd8);
    check("r1_high", hiw(0), 16'd3);
    check("r1_g_period", per(1), 16'd0);
    check("r1_b_period", per(2), 16'd0);
    prev_cyc = valid_cyc;
    tick();
    check("r1_pulse_len", valid_o, 3'b000);
    check("r1_hold_period", per(0), 16'd8);
    wait_valid(0, 0, 12, "r2");
    check("r2_gap", valid_cyc - prev_cyc, 32'd8);
    check("r2_period", per(0), 16'd8);
    check("r2_high", hiw(0), 16'd3);
    check("r2_gb_high", {hiw(1), hiw(2)}, 32'd0);

    // G: 50% then 11/12 then 0% (timeout low)
    do_reset();
    set_gen(1, 6, 12);
    wait_valid(0, 1, 40, "g50");
    check("g50_period", per(1), 16'd12);
    check("g50_high", hiw(1), 16'd6);
    gen_hi[1] = 11;
    wait_valid(0, 1, 20, "g92");
    check("g92_period", per(1), 16'd12);
    check("g92_high", hiw(1), 16'd11);
    hold_gen(1, 1'b0);
    prev_cyc = valid_cyc;
    wait_valid(0, 1, 150, "g0");
    check("g0_gap", valid_cyc - prev_cyc, 32'd100);
    check("g0_mask", valid_o, 3'b010);
    check("g0_period", per(1), 16'd0);
    check("g0_high", hiw(1), 16'd0);
    check("g0_stuck", stuck_o, 3'b010);
    check("g0_level", level_o[1], 1'b0);

    // B: period 10, then held high, then restarted
    do_reset();
    set_gen(2, 5, 10);
    wait_valid(0, 2, 40, "b1");
    check("b1_period", per(2), 16'd10);
    check("b1_high", hiw(2), 16'd5);
    hold_gen(2, 1'b1);
    prev_cyc = valid_cyc;
    wait_valid(0, 2, 150, "bto");
    check("bto_gap", valid_cyc - prev_cyc, 32'd100);
    check("bto_period", per(2), 16'd0);
    check("bto_stuck", stuck_o, 3'b100);
    check("bto_level", level_o[2], 1'b1);
    set_gen(2, 5, 10);
    vseen = '0;
    for (int i = 0; i < 16; i++) tick();
    check("brearm_novalid", vseen, 3'b000);
    check("brearm_stuck", stuck_o[2], 1'b1);
    wait_valid(0, 2, 20, "b2");
    check("b2_period", per(2), 16'd10);
    check("b2_high", hiw(2), 16'd5);
    check("b2_stuck", stuck_o[2], 1'b0);

    // Active-low pins: low 4 / high 6
    do_reset();
    set_gen(3, 4, 10);
    wait_valid(1, 0, 40, "al");
    check("al_mask", valid_al, 3'b001);
    check("al_period", period_al[15:0], 16'd10);
    check("al_high", high_al[15:0], 16'd4);
    check("al_stuck", stuck_al, 3'b000);

    // All channels in phase, then reset mid-period
    do_reset();
    for (int c = 0; c < 3; c++) set_gen(c, 4, 8);
    wait_valid(0, 0, 30, "all");
    check("all_mask", valid_o, 3'b111);
    check("all_period", period_o, {16'd8, 16'd8, 16'd8});
    check("all_high", high_o, {16'd4, 16'd4, 16'd4});
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_period", period_o, 48'd0);
    check("mid_rst_high", high_o, 48'd0);
    check("mid_rst_valid", valid_o, 3'b000);
    tick();
    tick();
    rst_n = 1'b1;
    vseen = '0;
    for (int i = 0; i < 6; i++) tick();
    check("post_rst_novalid", vseen, 3'b000);
    wait_valid(0, 0, 20, "post_rst");
    check("post_rst_mask", valid_o, 3'b111);
    check("post_rst_period", period_o, {16'd8, 16'd8, 16'd8});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
